// File: rtl/counter_b4_checker_pkg.sv
// Shared definitions for the 4-bit mode counter and its checker:
// counter width, mode encodings and checker FSM state encodings.
package counter_b4_defs;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    MODE_UP  = 2'b00,
    MODE_DN  = 2'b01,
    MODE_DN3 = 2'b10,
    MODE_LD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    TRACK = 2'b10
  } state_e;

endpackage

// File: rtl/counter_b4_checker_if.sv
// Stimulus and observed outputs of the counter under check, as seen by the checker.
interface counter_b4_checker_if;
  import counter_b4_defs::*;

  logic             chk_enable;
  logic [1:0]       chk_mode;
  logic [CNT_W-1:0] chk_D;
  logic [CNT_W-1:0] chk_Q;
  logic             chk_load;
  logic             chk_rco;

  modport master (
    output chk_enable, chk_mode, chk_D, chk_Q, chk_load, chk_rco
  );

  modport slave (
    input  chk_enable, chk_mode, chk_D, chk_Q, chk_load, chk_rco
  );

endinterface

// File: rtl/counter_b4_checker_model.sv
// Combinational next-state function of the 4-bit mode counter; the caller
// registers the outputs.
module counter_b4_model
  import counter_b4_defs::*;
(
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] d_i,
  input  logic [CNT_W-1:0] q_i,
  output logic [CNT_W-1:0] q_o,
  output logic             load_o,
  output logic             rco_o
);

  // Extra MSB of the subtraction is the borrow out of the down-by-3 step.
  logic [CNT_W:0] dn3;
  assign dn3 = {1'b0, q_i} - (CNT_W + 1)'(3);

  always_comb begin
    q_o    = q_i;
    load_o = 1'b0;
    rco_o  = 1'b0;
    if (enable_i) begin
      case (mode_e'(mode_i))
        MODE_UP: begin
          q_o   = q_i + CNT_W'(1);
          rco_o = (q_i == {CNT_W{1'b1}});
        end
        MODE_DN: begin
          q_o   = q_i - CNT_W'(1);
          rco_o = (q_i == '0);
        end
        MODE_DN3: begin
          q_o   = dn3[CNT_W-1:0];
          rco_o = dn3[CNT_W];
        end
        MODE_LD: begin
          q_o    = d_i;
          load_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/counter_b4_checker.sv
// Cycle-accurate checker for the 4-bit mode counter: predicts {Q,load,rco}
// one cycle ahead, flags mismatches and counts errors and rco events.
module counter_b4_checker
  import counter_b4_defs::*;
#(
  parameter int ERR_W = 8
) (
  input  logic                 chk_clk,
  input  logic                 chk_reset,
  counter_b4_checker_if.slave  bus,
  output logic                 chk_err,
  output logic [ERR_W-1:0]     chk_err_cnt,
  output logic [ERR_W-1:0]     chk_rco_cnt,
  output logic                 chk_fail,
  output logic [1:0]           chk_state
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pred_cnt_q, pred_cnt_d;
  logic             pred_load_q, pred_load_d;
  logic             pred_rco_q, pred_rco_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] rco_cnt_q, rco_cnt_d;
  logic             fail_q, fail_d;

  logic [CNT_W+1:0] obs_vec, pred_vec;
  logic             obs_x;
  logic             mismatch;
  logic [CNT_W-1:0] cur_q;
  logic [CNT_W-1:0] mdl_q;
  logic             mdl_load, mdl_rco;

  assign obs_vec  = {bus.chk_Q, bus.chk_load, bus.chk_rco};
  assign pred_vec = {pred_cnt_q, pred_load_q, pred_rco_q};
  // Unknown observed values only exist in simulation; they always count as a mismatch.
  assign obs_x    = $isunknown(obs_vec);

  // Compare stage: observed outputs versus last cycle's prediction
  always_comb begin
    mismatch = 1'b0;
    case (state_q)
      SYNC:    mismatch = obs_x || (obs_vec != '0);
      TRACK:   mismatch = obs_x || (obs_vec != pred_vec);
      default: mismatch = 1'b0;
    endcase
    // Resynchronise to the counter so a single fault is reported once.
    cur_q = (mismatch && !obs_x) ? bus.chk_Q : pred_cnt_q;
  end

  counter_b4_model u_model (
    .enable_i (bus.chk_enable),
    .mode_i   (bus.chk_mode),
    .d_i      (bus.chk_D),
    .q_i      (cur_q),
    .q_o      (mdl_q),
    .load_o   (mdl_load),
    .rco_o    (mdl_rco)
  );

  always_comb begin
    state_d     = state_q;
    pred_cnt_d  = pred_cnt_q;
    pred_load_d = pred_load_q;
    pred_rco_d  = pred_rco_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    rco_cnt_d   = rco_cnt_q;
    fail_d      = fail_q;

    case (state_q)
      IDLE: begin
        state_d     = SYNC;
        pred_cnt_d  = '0;
        pred_load_d = 1'b0;
        pred_rco_d  = 1'b0;
      end
      SYNC, TRACK: begin
        state_d     = TRACK;
        pred_cnt_d  = mdl_q;
        pred_load_d = mdl_load;
        pred_rco_d  = mdl_rco;
      end
      default: state_d = IDLE;
    endcase

    if (mismatch) begin
      err_d     = 1'b1;
      err_cnt_d = sat_inc(err_cnt_q);
      fail_d    = 1'b1;
    end else if (state_q == TRACK && bus.chk_rco && pred_rco_q) begin
      rco_cnt_d = rco_cnt_q + 1'b1;
    end
  end

  // Prediction / result register stage
  always_ff @(posedge chk_clk or negedge chk_reset) begin
    if (!chk_reset) begin
      state_q     <= IDLE;
      pred_cnt_q  <= '0;
      pred_load_q <= 1'b0;
      pred_rco_q  <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      rco_cnt_q   <= '0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pred_cnt_q  <= pred_cnt_d;
      pred_load_q <= pred_load_d;
      pred_rco_q  <= pred_rco_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      rco_cnt_q   <= rco_cnt_d;
      fail_q      <= fail_d;
    end
  end

  assign chk_err     = err_q;
  assign chk_err_cnt = err_cnt_q;
  assign chk_rco_cnt = rco_cnt_q;
  assign chk_fail    = fail_q;
  assign chk_state   = state_q;

endmodule

// File: tb/tb_counter_b4_checker.sv
// Bench for counter_b4_checker: plays the counter (with optional faults) and
// checks two checker instances (ERR_W=8 and ERR_W=2) against a reference.
module tb_counter_b4_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_b4_checker_if bus();

  logic       err8, fail8, err2, fail2;
  logic [7:0] ecnt8, rcnt8;
  logic [1:0] ecnt2, rcnt2;
  logic [1:0] st8, st2;

  counter_b4_checker #(.ERR_W(8)) u8 (
    .chk_clk(clk), .chk_reset(rst_n), .bus(bus),
    .chk_err(err8), .chk_err_cnt(ecnt8), .chk_rco_cnt(rcnt8),
    .chk_fail(fail8), .chk_state(st8)
  );

  counter_b4_checker #(.ERR_W(2)) u2 (
    .chk_clk(clk), .chk_reset(rst_n), .bus(bus),
    .chk_err(err2), .chk_err_cnt(ecnt2), .chk_rco_cnt(rcnt2),
    .chk_fail(fail2), .chk_state(st2)
  );

  typedef struct {
    int q;
    bit load;
    bit rco;
  } out_t;

  typedef struct {
    bit en;
    int mode;
    int d;
    int inj;
    int iv;
    int st;
    int err;
    int ecnt;
    int rcnt;
  } vec_t;

  vec_t tbl[$];
  out_t cnt;
  out_t pend;
  int   ref_st, ref_err, ref_fail, ref_e8, ref_e2, ref_r8, ref_r2;
  int   n_pass = 0;
  int   n_total = 0;

  // Counter behaviour written straight from the mode rules.
  function automatic out_t rule(bit en, int mode, int d, int q);
    out_t o;
    o.q = q; o.load = 1'b0; o.rco = 1'b0;
    if (en) begin
      case (mode)
        0:       begin o.q = (q + 1) % 16;  o.rco = (q == 15); end
        1:       begin o.q = (q + 15) % 16; o.rco = (q == 0);  end
        2:       begin o.q = (q + 13) % 16; o.rco = (q < 3);   end
        default: begin o.q = d;             o.load = 1'b1;     end
      endcase
    end
    return o;
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
  endtask

  task automatic drive_obs();
    bus.chk_Q    = 4'(cnt.q);
    bus.chk_load = cnt.load;
    bus.chk_rco  = cnt.rco;
  endtask

  task automatic set_in(bit en, int mode, int d);
    bus.chk_enable = en;
    bus.chk_mode   = 2'(mode);
    bus.chk_D      = 4'(d);
  endtask

  task automatic ref_reset();
    ref_st = 0; ref_err = 0; ref_fail = 0;
    ref_e8 = 0; ref_e2 = 0; ref_r8 = 0; ref_r2 = 0;
    pend.q = 0; pend.load = 1'b0; pend.rco = 1'b0;
    cnt.q = 0; cnt.load = 1'b0; cnt.rco = 1'b0;
    drive_obs();
  endtask

  task automatic check_all(string tag);
    check({tag, ".err8"},  int'(err8),  ref_err);
    check({tag, ".ecnt8"}, int'(ecnt8), ref_e8);
    check({tag, ".rcnt8"}, int'(rcnt8), ref_r8);
    check({tag, ".fail8"}, int'(fail8), ref_fail);
    check({tag, ".st8"},   int'(st8),   ref_st);
    check({tag, ".err2"},  int'(err2),  ref_err);
    check({tag, ".ecnt2"}, int'(ecnt2), ref_e2);
    check({tag, ".rcnt2"}, int'(rcnt2), ref_r2);
    check({tag, ".fail2"}, int'(fail2), ref_fail);
    check({tag, ".st2"},   int'(st2),   ref_st);
  endtask

  // One clock: the counter updates from the pre-edge inputs (inj: 1 force Q,
  // 2 flip load, 3 flip rco, 4 flip Q MSB), the reference checker judges the
  // pre-edge observed outputs, then both DUTs are compared.
  task automatic step(string tag, int inj, int iv);
    bit   s_en;
    int   s_mode, s_d, s_st;
    out_t s_obs, nxt;
    bit   mism;
    s_en = bus.chk_enable; s_mode = int'(bus.chk_mode); s_d = int'(bus.chk_D);
    s_obs = cnt; s_st = ref_st;
    @(posedge clk);
    #1;
    if (!rst_n) return;
    nxt = rule(s_en, s_mode, s_d, s_obs.q);
    case (inj)
      1: nxt.q = iv;
      2: nxt.load = !nxt.load;
      3: nxt.rco = !nxt.rco;
      4: nxt.q = nxt.q ^ 8;
      default: ;
    endcase
    cnt = nxt;
    drive_obs();
    mism = 1'b0;
    case (s_st)
      0: ref_st = 1;
      1: begin
        mism = (s_obs.q != 0) || s_obs.load || s_obs.rco;
        pend = rule(s_en, s_mode, s_d, s_obs.q);
        ref_st = 2;
      end
      default: begin
        mism = (s_obs.q != pend.q) || (s_obs.load != pend.load) || (s_obs.rco != pend.rco);
        pend = rule(s_en, s_mode, s_d, s_obs.q);
      end
    endcase
    ref_err = int'(mism);
    if (mism) begin
      ref_fail = 1;
      if (ref_e8 < 255) ref_e8++;
      if (ref_e2 < 3) ref_e2++;
    end else if (s_st == 2 && s_obs.rco) begin
      ref_r8 = (ref_r8 + 1) % 256;
      ref_r2 = (ref_r2 + 1) % 4;
    end
    check_all(tag);
  endtask

  task automatic add(int n, bit en, int mode, int d, int inj, int iv,
                     int st, int err, int ecnt, int rcnt);
    vec_t v;
    v.en = en; v.mode = mode; v.d = d; v.inj = inj; v.iv = iv;
    v.st = st; v.err = err; v.ecnt = ecnt; v.rcnt = rcnt;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    // Expectations are what the checker shows right after each row's edge.
    add(1,  0, 0, 0,  0, 0, 1, 0, 0, 0);  // IDLE -> SYNC
    add(1,  0, 0, 0,  0, 0, 2, 0, 0, 0);  // SYNC -> TRACK
    add(16, 1, 0, 0,  0, 0, 2, 0, 0, 0);  // up 1..15,0
    add(4,  1, 0, 0,  0, 0, 2, 0, 0, 1);  // 15->0 rco counted
    add(2,  1, 2, 0,  0, 0, 2, 0, 0, 1);  // 4 -> 1 -> 14 (rco)
    add(1,  1, 3, 10, 0, 0, 2, 0, 0, 2);  // load A
    add(11, 1, 1, 0,  0, 0, 2, 0, 0, 2);  // down 9..0,15
    add(1,  1, 1, 0,  0, 0, 2, 0, 0, 3);  // 0->15 rco counted
    add(10, 1, 1, 0,  0, 0, 2, 0, 0, 3);  // down to 4
    add(1,  1, 1, 0,  1, 5, 2, 0, 0, 3);  // expect 3, counter shows 5
    add(1,  1, 1, 0,  0, 0, 2, 1, 1, 3);  // single error pulse
    add(3,  1, 1, 0,  0, 0, 2, 0, 1, 3);  // no repeats after resync

    set_in(1'b0, 0, 0);
    ref_reset();
    #2;
    check("rst.state8", int'(st8), 0);
    check("rst.ecnt8",  int'(ecnt8), 0);
    check("rst.fail8",  int'(fail8), 0);
    repeat (3) step("rst", 0, 0);
    #3 rst_n = 1'b1;

    foreach (tbl[i]) begin
      set_in(tbl[i].en, tbl[i].mode, tbl[i].d);
      step("tbl", tbl[i].inj, tbl[i].iv);
      check($sformatf("tbl%0d.state", i), int'(st8),   tbl[i].st);
      check($sformatf("tbl%0d.err", i),   int'(err8),  tbl[i].err);
      check($sformatf("tbl%0d.ecnt", i),  int'(ecnt8), tbl[i].ecnt);
      check($sformatf("tbl%0d.rcnt", i),  int'(rcnt8), tbl[i].rcnt);
      check($sformatf("tbl%0d.fail", i),  int'(fail8), int'(tbl[i].ecnt != 0));
    end

    // Five more faults: the narrow error counter must stop at 3.
    set_in(1'b1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step("flt", 4, 0);
      step("flt", 0, 0);
      step("flt", 0, 0);
    end
    check("sat.ecnt2", int'(ecnt2), 3);
    check("sat.ecnt8", int'(ecnt8), 6);
    check("sat.fail2", int'(fail2), 1);

    // Asynchronous reset in the middle of TRACK takes effect without a clock.
    #2 rst_n = 1'b0;
    ref_reset();
    #1;
    check("arst.err8",  int'(err8), 0);
    check("arst.ecnt8", int'(ecnt8), 0);
    check("arst.rcnt8", int'(rcnt8), 0);
    check("arst.fail8", int'(fail8), 0);
    check("arst.st8",   int'(st8), 0);
    check("arst.ecnt2", int'(ecnt2), 0);
    check("arst.rcnt2", int'(rcnt2), 0);
    check("arst.st2",   int'(st2), 0);
    set_in(1'b0, 0, 0);
    repeat (2) step("arst", 0, 0);
    #2 rst_n = 1'b1;
    step("rel", 0, 0);
    check("rel.sync", int'(st8), 1);
    step("rel", 0, 0);
    check("rel.track", int'(st8), 2);

    for (int k = 0; k < 400; k++) begin
      int inj;
      set_in($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      inj = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 4)) : 0;
      step("rnd", inj, int'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_b4_checker.md
# counter_b4_checker

Self-checking receiver for the 4-bit mode counter's output interface (Q, load, rco). It watches the same stimulus the counter sees (enable, mode, D) and keeps a cycle-accurate reference model of the counter. It compares the counter's registered outputs against the model every cycle and accumulates error and ripple-carry statistics. It sits beside the behavioral or synthesized counter in the testbenches, and can be instantiated twice to cross-check both netlists in one run.

## Interface
- `ERR_W`, default 8: width of the error and rco event counters.
- `chk_clk` input, 1: clock, shared with the counter under check.
- `chk_reset` input, 1: asynchronous, active-low reset.
- `chk_enable` input, 1: counter enable, as driven to the counter.
- `chk_mode` input, 2: counter mode, as driven to the counter.
- `chk_D` input, 4: counter parallel-load data.
- `chk_Q` input, 4: observed counter value.
- `chk_load` input, 1: observed load flag.
- `chk_rco` input, 1: observed ripple-carry flag.
- `chk_err` output, 1: one-cycle pulse on any mismatch.
- `chk_err_cnt` output, ERR_W: count of mismatching cycles, saturating.
- `chk_rco_cnt` output, ERR_W: count of correctly predicted rco events, wrapping.
- `chk_fail` output, 1: sticky flag, set on the first mismatch.
- `chk_state` output, 2: FSM state, for waveform debug.

## Operation
- **Counter model.** All outputs are registered and update on the same edge.
  - Reset value: Q=0, load=0, rco=0.
  - enable=0: Q holds; load=0, rco=0.
  - mode 00: Q+1. rco=1 when the old Q is 15 (wraps to 0).
  - mode 01: Q-1. rco=1 when the old Q is 0 (wraps to 15).
  - mode 10: Q-3, mod 16. rco=1 when the old Q is below 3.
  - mode 11: Q takes D; load=1, rco=0.
  - In every other case load=0.
- **Width rules.** Model arithmetic is 4-bit modulo 16. Borrow detection uses a 5-bit intermediate.
- **FSM states.** The three states are IDLE=00, SYNC=01 and TRACK=10.
  - IDLE: entered by reset. The model is zeroed. On the first clock with reset released, go to SYNC.
  - SYNC: compare the observed outputs against the reset value (Q=0, load=0, rco=0), then go to TRACK. A mismatch counts as an error.
  - TRACK: each cycle, compare the observed {Q,load,rco} with the model's prediction from the previous cycle's inputs. On a mismatch, pulse chk_err, then resynchronise the model Q to the observed chk_Q so that one fault is not reported every cycle afterwards.
- **Counters.**
  - chk_err_cnt increments on each chk_err pulse and saturates at all-ones.
  - chk_rco_cnt increments when the observed rco and the predicted rco are both 1.
- **chk_fail.** Cleared only by reset.
- **Simultaneous events.** A mismatch and a correct rco in the same cycle cannot occur, because a mismatch excludes a correct rco. If rco matches but Q differs, the cycle is a mismatch and chk_rco_cnt does not increment.

## Timing
- **Reset values.** Async assertion forces: chk_err=0, chk_err_cnt=0, chk_rco_cnt=0, chk_fail=0, chk_state=IDLE, model Q=0. This takes effect immediately, without waiting for a clock edge.
- **Reset mid-operation.** Assertion aborts TRACK, and the model restarts from IDLE.
- **Compare latency.** Inputs sampled at edge n produce counter outputs after edge n+1. The checker compares those outputs at edge n+2, so chk_err is registered and appears 1 cycle after the offending counter output.
- **Pipeline.** The previous-cycle prediction is held in one register stage (pred_Q, pred_load, pred_rco).
- **X handling.** In TRACK, any X or Z on the observed outputs counts as a mismatch. This check is for simulation only; synthesis ignores it.

## Structure
- Shared package or include file `counter_b4_defs`. It holds:
  - the mode constants MODE_UP=2'b00, MODE_DN=2'b01, MODE_DN3=2'b10, MODE_LD=2'b11;
  - the FSM state encodings;
  - the counter width 4.
- Sub-module `counter_b4_model`: combinational next-state function.
  - Inputs: enable, mode, D, current Q.
  - Outputs: next Q, load, rco.
  - The checker registers its outputs. Future counter variants reuse it.

## Test plan
1. Reset low for 3 cycles, then released with enable=0 → SYNC then TRACK; chk_err_cnt=0, chk_fail=0.
2. mode=00, enable=1 for 20 cycles from Q=0 → one rco (15→0) counted, so chk_rco_cnt=1 and no errors.
3. mode=11, D=4'hA, then mode=01 for 12 cycles → load=1 on the load cycle. The wrap 0→15 gives one rco, so chk_rco_cnt=1 and chk_err_cnt=0.
4. mode=10 from Q=4 → predicted sequence 1, 14 with rco on the 1→14 step; chk_rco_cnt=1.
5. Fault injection: force the observed chk_Q to 5 for one cycle while the model expects 3 → a single chk_err pulse one cycle later, chk_err_cnt=1, chk_fail=1, no repeated errors after resync.
6. ERR_W=2 with 5 injected faults, then async reset mid-TRACK → chk_err_cnt saturates at 3; after reset all outputs return to 0 and state returns to IDLE.
